// File: rtl/fetch_pkg.sv
// Shared fetch-unit definitions: FSM state encoding, instruction size, halt sentinel.
// Used by fetch_unit (FETCH_HALT_EN selects the halt-on-zero-word behaviour) and pc_next_gen.
package fetch_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      ISSUE = 2'd2,
      HALT  = 2'd3
   } fetch_state_t;

   localparam int unsigned INST_BYTES = 4;
   localparam logic [31:0] HALT_WORD  = 32'h0000_0000;

endpackage

// File: rtl/pc_next_gen.sv
// Next-PC select: sequential PC+4 (wraps modulo 2^DWIDTH) or word-aligned ALU target.
// Purely combinational, zero latency, no backpressure.
module pc_next_gen
   import fetch_pkg::*;
#(
   parameter int unsigned DWIDTH = 32
)(
   input  logic [DWIDTH-1:0] i_pc,
   input  logic              i_pcsel,
   input  logic [DWIDTH-1:0] i_alu_target,
   output logic [DWIDTH-1:0] o_next_pc
);

   logic [DWIDTH-1:0] w_seq_pc;
   logic [DWIDTH-1:0] w_jmp_pc;

   assign w_seq_pc  = i_pc + DWIDTH'(INST_BYTES);
   // Targets are forced to a word boundary; the low address bits are dropped.
   assign w_jmp_pc  = {i_alu_target[DWIDTH-1:2], 2'b00};
   assign o_next_pc = i_pcsel ? w_jmp_pc : w_seq_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch FSM: FETCH -> WAIT -> ISSUE, min 3 cycles/instruction; ISSUE holds until inst_ready.
// Optional FETCH_HALT_EN: a zero word captured in WAIT parks the FSM in HALT until reset.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned       DWIDTH   = 32,
   parameter logic [DWIDTH-1:0] RESET_PC = 32'h0000_0000
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              PCSel,
   input  logic [DWIDTH-1:0] alu_target,
   output logic              imem_req,
   output logic [DWIDTH-1:0] imem_addr,
   input  logic              imem_rvalid,
   input  logic [31:0]       imem_rdata,
   output logic [31:0]       instruction,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [DWIDTH-1:0] pc,
   output logic              halted
);

   fetch_state_t      r_state;
   fetch_state_t      w_state_nxt;
   logic [DWIDTH-1:0] r_pc;
   logic [DWIDTH-1:0] w_pc_nxt;
   logic [31:0]       r_instruction;
   logic              w_inst_load;
   logic              w_pc_load;
   logic              w_is_halt_word;
   logic              w_req;
   logic              w_valid;

   pc_next_gen #(
      .DWIDTH (DWIDTH)
   ) u_pc_next_gen (
      .i_pc         (r_pc),
      .i_pcsel      (PCSel),
      .i_alu_target (alu_target),
      .o_next_pc    (w_pc_nxt)
   );

`ifdef FETCH_HALT_EN
   assign w_is_halt_word = (imem_rdata == HALT_WORD);
   assign halted         = (r_state == HALT);
`else
   assign w_is_halt_word = 1'b0;
   assign halted         = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= FETCH;
         r_pc          <= RESET_PC;
         r_instruction <= 32'h0;
      end else begin
         r_state <= w_state_nxt;
         if (w_pc_load)
            r_pc <= w_pc_nxt;
         if (w_inst_load)
            r_instruction <= imem_rdata;
      end
   end

   // rvalid is only looked at in WAIT, so late or coincident responses fall on the floor.
   always_comb begin
      w_state_nxt = r_state;
      w_inst_load = 1'b0;
      w_pc_load   = 1'b0;
      w_req       = 1'b0;
      w_valid     = 1'b0;
      case (r_state)
         FETCH: begin
            w_req       = 1'b1;
            w_state_nxt = WAIT;
         end
         WAIT: begin
            if (imem_rvalid) begin
               w_inst_load = 1'b1;
               w_state_nxt = w_is_halt_word ? HALT : ISSUE;
            end
         end
         ISSUE: begin
            w_valid = 1'b1;
            if (inst_ready) begin
               w_pc_load   = 1'b1;
               w_state_nxt = FETCH;
            end
         end
         HALT:    w_state_nxt = HALT;
         default: w_state_nxt = FETCH;
      endcase
   end

   // Reset parks the FSM in FETCH; the request is masked until rst_n releases.
   assign imem_req    = w_req & rst_n;
   assign imem_addr   = r_pc;
   assign pc          = r_pc;
   assign instruction = r_instruction;
   assign inst_valid  = w_valid;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The module SHALL have parameter DWIDTH, default 32, giving the PC and address width in bits.
REQ-002 The module SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC loaded at reset.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port PCSel, input, 1 bit: next-PC select from control; 0 = PC+4, 1 = alu_target.
REQ-006 The module SHALL have port alu_target, input, DWIDTH bits: branch/jump target from the ALU.
REQ-007 The module SHALL have port imem_req, output, 1 bit: instruction-memory read request, one-cycle pulse.
REQ-008 The module SHALL have port imem_addr, output, DWIDTH bits: read address, equal to pc.
REQ-009 The module SHALL have port imem_rvalid, input, 1 bit: instruction-memory read data valid.
REQ-010 The module SHALL have port imem_rdata, input, 32 bits: instruction-memory read data.
REQ-011 The module SHALL have port instruction, output, 32 bits: fetched instruction driven to control.
REQ-012 The module SHALL have port inst_valid, output, 1 bit: instruction holds a valid word.
REQ-013 The module SHALL have port inst_ready, input, 1 bit: downstream accepts the instruction.
REQ-014 The module SHALL have port pc, output, DWIDTH bits: address of the current instruction.
REQ-015 The module SHALL have port halted, output, 1 bit: fetch stopped on the halt word.

Function
REQ-016 The FSM SHALL have four states: FETCH, WAIT, ISSUE and HALT.
REQ-017 In FETCH, imem_req SHALL be 1 for exactly one cycle with imem_addr=pc, and the FSM SHALL move to WAIT the next cycle.
REQ-018 In WAIT, the FSM SHALL stay until imem_rvalid=1; it SHALL then capture imem_rdata into instruction and enter ISSUE, so inst_valid rises one cycle after rvalid.
REQ-019 imem_rvalid SHALL be ignored in every state other than WAIT, so rvalid coincident with imem_req is dropped.
REQ-020 In ISSUE, inst_valid SHALL be 1 and instruction and pc SHALL be held stable until inst_ready=1.
REQ-021 On the ISSUE handshake (inst_valid and inst_ready both 1), pc SHALL load pc+4 if PCSel=0, else alu_target with bits [1:0] forced to 0; the FSM SHALL then return to FETCH.
REQ-022 PCSel and alu_target SHALL be sampled only in the handshake cycle.
REQ-023 inst_ready=1 in the first ISSUE cycle SHALL complete the handshake in that cycle.
REQ-024 The PC+4 arithmetic SHALL be modulo 2^DWIDTH, so 32'hFFFF_FFFC increments to 32'h0000_0000.
REQ-025 Fetch-to-fetch throughput SHALL be 3 cycles minimum: FETCH, WAIT (rvalid in the first WAIT cycle) and ISSUE (ready immediately).

Reset
REQ-026 While rst_n=0, the state SHALL be FETCH, pc SHALL be RESET_PC, instruction SHALL be 32'h0, and imem_req, inst_valid and halted SHALL be 0.
REQ-027 A reset asserted in any state, including WAIT with a read outstanding, SHALL abort the read; any rvalid that arrives late SHALL be discarded under REQ-019.
REQ-028 The first imem_req SHALL be issued in the first clock cycle after rst_n deasserts.

Configuration
REQ-029 With FETCH_HALT_EN defined, an imem_rdata word of 32'h0000_0000 captured in WAIT SHALL send the FSM to HALT instead of ISSUE.
REQ-030 In HALT, halted SHALL be 1, inst_valid and imem_req SHALL be 0, and only reset SHALL exit the state.
REQ-031 Without FETCH_HALT_EN, an all-zero word SHALL be issued like any other word, and halted SHALL be tied to 0.

Structure
REQ-032 Package fetch_pkg SHALL hold the FSM state enum, INST_BYTES=4 and HALT_WORD=32'h0000_0000.
REQ-033 The next-PC mux and adder SHALL be a sub-module named pc_next_gen; everything else SHALL be inline.

Verification
REQ-034 Reset with RESET_PC=0, rvalid one cycle after req with rdata 32'h00500113, inst_ready=1 -> inst_valid with instruction 32'h00500113 and pc 0, then the next imem_addr=4.
REQ-035 Hold inst_ready=0 for 5 cycles on 32'h400102b3 -> inst_valid, instruction and pc held stable, with no imem_req.
REQ-036 Handshake with PCSel=1 and alu_target=32'h0000_0023 -> next imem_addr=32'h0000_0020.
REQ-037 pc=32'hFFFF_FFFC with PCSel=0 -> next imem_addr=32'h0000_0000.
REQ-038 With FETCH_HALT_EN, rdata 32'h00000000 -> halted=1 and no further imem_req; without it -> issued with inst_valid=1.
REQ-039 rst_n pulsed low during WAIT, then a stray rvalid in FETCH -> the stray rvalid is ignored and the fetch restarts at RESET_PC.
